// File: rtl/sync_mem_2p_if.sv
// Request/response bundle for sync_mem_2p: one write port, one read port, read response.
// master drives requests; slave is the memory.
interface sync_mem_2p_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 8
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_valid;
    logic              rd_ready;
    logic [AW-1:0]     rd_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr,
        output wr_ready, rd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sync_mem_2p.sv
// Single-clock simple-dual-port RAM with byte enables, registered read, selectable
// read-during-write behaviour, out-of-range detection and a zeroing sweep.
module sync_mem_2p #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    output logic          busy_o,
    sync_mem_2p_if.slave  bus
);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1  = AW + 1;
    localparam int unsigned BE_W = DATA_W / 8;

    localparam logic [AW:0]   DepthW   = AW1'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    localparam logic [1:0] StReset = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StReady = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready;
    logic              wr_in_range, rd_in_range;
    logic              wr_fire, rd_fire;
    logic [DATA_W-1:0] rd_word;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    assign ready        = (state_q == StReady) && !clear_i;
    assign busy_o       = (state_q != StReady);
    assign bus.wr_ready = ready;
    assign bus.rd_ready = ready;

    assign wr_in_range = ({1'b0, bus.wr_addr} < DepthW);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DepthW);
    // Out-of-range writes are accepted but never reach the array.
    assign wr_fire     = bus.wr_valid && ready && wr_in_range;
    assign rd_fire     = bus.rd_valid && ready;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StReset: begin
                clr_ptr_d = '0;
                state_d   = (CLEAR_ON_RESET != 0) ? StClear : StReady;
            end
            StClear: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LastAddr) state_d = StReady;
            end
            StReady: begin
                if (clear_i) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StReset;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && (state_q == StClear)) begin
            mem_q[clr_ptr_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.wr_be[i]) mem_q[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
            end
        end
    end

    // New-data mode forwards the enabled write bytes over the pre-write word.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[bus.rd_addr];
            if ((RDW_MODE != 0) && wr_fire && (bus.wr_addr == bus.rd_addr)) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (bus.wr_be[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rd_fire;
            if (rd_fire) begin
                rsp_data_q <= rd_word;
                rsp_err_q  <= !rd_in_range;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_sync_mem_2p.sv
// Bench for sync_mem_2p: two instances (256 words old-data, 200 words new-data) driven in
// lockstep and compared against per-instance array models.
module tb_sync_mem_2p;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned DA = 256;
    localparam int unsigned DB = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy_a, busy_b;

    always #5 clk = ~clk;

    sync_mem_2p_if #(.DATA_W(DW), .AW(AW)) if_a ();
    sync_mem_2p_if #(.DATA_W(DW), .AW(AW)) if_b ();

    sync_mem_2p #(.DATA_W(DW), .DEPTH(DA), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy_a), .bus(if_a.slave)
    );
    sync_mem_2p #(.DATA_W(DW), .DEPTH(DB), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .busy_o(busy_b), .bus(if_b.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_a [DA];
    logic [31:0] ref_b [DB];
    logic [31:0] last_a, last_b;
    logic        last_err_a, last_err_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                         input logic [3:0] wbe, input logic rv, input logic [7:0] ra);
        if_a.wr_valid = wv; if_a.wr_addr = wa; if_a.wr_data = wd; if_a.wr_be = wbe;
        if_a.rd_valid = rv; if_a.rd_addr = ra;
        if_b.wr_valid = wv; if_b.wr_addr = wa; if_b.wr_data = wd; if_b.wr_be = wbe;
        if_b.rd_valid = rv; if_b.rd_addr = ra;
    endtask

    task automatic clear_models();
        for (int i = 0; i < DA; i++) ref_a[i] = '0;
        for (int i = 0; i < DB; i++) ref_b[i] = '0;
        last_a = '0; last_b = '0; last_err_a = 1'b0; last_err_b = 1'b0;
    endtask

    // One accepted cycle: A sees the pre-write word, B sees the word after the write lands.
    task automatic step(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [3:0] wbe, input logic rv, input logic [7:0] ra);
        logic [31:0] ea, eb;
        logic        errb;
        drive(wv, wa, wd, wbe, rv, ra);
        #1;
        chk("wr_ready_a", {31'b0, if_a.wr_ready}, 32'd1);
        chk("rd_ready_b", {31'b0, if_b.rd_ready}, 32'd1);
        ea = ref_a[ra];
        if (wv) begin
            for (int i = 0; i < 4; i++) if (wbe[i]) ref_a[wa][8*i +: 8] = wd[8*i +: 8];
            if (wa < DB)
                for (int i = 0; i < 4; i++) if (wbe[i]) ref_b[wa][8*i +: 8] = wd[8*i +: 8];
        end
        if (ra < DB) begin eb = ref_b[ra]; errb = 1'b0; end
        else begin eb = '0; errb = 1'b1; end
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
        if (rv) begin
            last_a = ea; last_err_a = 1'b0; last_b = eb; last_err_b = errb;
        end
        chk("rsp_valid_a", {31'b0, if_a.rsp_valid}, {31'b0, rv});
        chk("rsp_valid_b", {31'b0, if_b.rsp_valid}, {31'b0, rv});
        chk("rsp_data_a", if_a.rsp_data, last_a);
        chk("rsp_data_b", if_b.rsp_data, last_b);
        chk("rsp_err_a", {31'b0, if_a.rsp_err}, {31'b0, last_err_a});
        chk("rsp_err_b", {31'b0, if_b.rsp_err}, {31'b0, last_err_b});
    endtask

    // Counts busy cycles from rst_n rising while hammering writes that must be dropped.
    task automatic wait_sweep();
        int na, nb;
        bit done_b;
        na = 0; nb = 0; done_b = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (busy_b && !done_b) nb++;
            else done_b = 1'b1;
            if (!busy_a) break;
            na++;
            if_a.wr_valid = 1'b1; if_a.wr_addr = 8'($urandom_range(0, 255));
            if_a.wr_data = 32'hFFFF_FFFF; if_a.wr_be = 4'hF;
            if_b.wr_valid = busy_b; if_b.wr_addr = 8'($urandom_range(0, 199));
            if_b.wr_data = 32'hFFFF_FFFF; if_b.wr_be = 4'hF;
        end
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
        chk("busy_len_a", na, DA);
        chk("busy_len_b", nb, DB);
    endtask

    task automatic read_all();
        for (int i = 0; i < DA; i++) step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'(i));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a", {31'b0, busy_a}, 32'd1);
        chk("rst_busy_b", {31'b0, busy_b}, 32'd1);
        chk("rst_rsp_valid_a", {31'b0, if_a.rsp_valid}, 32'd0);
        chk("rst_rsp_data_a", if_a.rsp_data, 32'd0);
        chk("rst_rsp_err_b", {31'b0, if_b.rsp_err}, 32'd0);
        chk("rst_ready_a", {31'b0, if_a.wr_ready}, 32'd0);
        rst_n = 1'b1;
        wait_sweep();
        clear_models();
        read_all();

        // Byte-enable merge
        step(1'b1, 8'd5, 32'hAABB_CCDD, 4'hF, 1'b0, 8'd0);
        step(1'b1, 8'd5, 32'h1122_3344, 4'b0101, 1'b0, 8'd0);
        step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5);
        chk("be_merge_a", if_a.rsp_data, 32'hAA22_CC44);
        chk("be_merge_b", if_b.rsp_data, 32'hAA22_CC44);

        // Read-during-write on a zeroed word
        step(1'b1, 8'd9, 32'hFFFF_FFFF, 4'hF, 1'b1, 8'd9);
        chk("rdw_old_a", if_a.rsp_data, 32'h0);
        chk("rdw_new_b", if_b.rsp_data, 32'hFFFF_FFFF);

        // Out-of-range on the 200-word instance
        step(1'b1, 8'd210, 32'h1234_5678, 4'hF, 1'b0, 8'd0);
        step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd210);
        chk("oor_err_b", {31'b0, if_b.rsp_err}, 32'd1);
        chk("oor_data_b", if_b.rsp_data, 32'd0);
        chk("inr_data_a", if_a.rsp_data, 32'h1234_5678);
        read_all();

        // Fill with random data, then clear, abort by reset mid-sweep
        for (int i = 0; i < 40; i++)
            step(1'b1, 8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)),
                 1'b1, 8'($urandom_range(0, 255)));
        clear = 1'b1;
        #1;
        chk("clear_ready_a", {31'b0, if_a.wr_ready}, 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_busy_a", {31'b0, busy_a}, 32'd1);
        repeat (49) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_b", {31'b0, busy_b}, 32'd1);
        chk("abort_rsp_data_a", if_a.rsp_data, 32'd0);
        rst_n = 1'b1;
        wait_sweep();
        clear_models();
        read_all();

        // Back-to-back reads with random writes alongside
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                 1'b1, 8'(i));
            if (if_a.rsp_valid === 1'b1 && if_b.rsp_valid === 1'b1) pulses++;
        end
        chk("b2b_pulses", pulses, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
